// File: rtl/codec_dac_bus_parser.sv
// codec_dac_bus_parser
//   Recovers left/right audio words from an I2S DAC bus (BCLK, DACLRCK,
//   DACDAT) that is asynchronous to CLK. The word pair is presented on the
//   channel outputs with a one-cycle DATA_VALID strobe. A channel word that
//   closes with fewer than DATA_WIDTH bits raises a one-cycle FRAME_ERR.
//
// Ports
//   CLK          system clock; all flops clock on its rising edge
//   RESET_N      synchronous active-low reset
//   AUD_BCLK     codec bit clock (period >= 4 CLK)
//   AUD_DACLRCK  frame clock: 0 = left, 1 = right
//   AUD_DACDAT   serial data, MSB first, one-bit I2S delay after LRCK edge
//   LCHAN_DATA   last complete left word
//   RCHAN_DATA   last complete right word
//   DATA_VALID   one-cycle strobe when both channel outputs update
//   FRAME_ERR    one-cycle strobe when a channel word closes short
//
// Timing: an AUD_BCLK rise first seen at edge E0 reaches the synchronizer
// output at E1 and is detected as a rise in that cycle. E2 registers the
// rise event with its LRCK/DAT samples, E3 runs the parser, and E4 drives
// DATA_VALID / FRAME_ERR. DATA_VALID therefore rises 4 cycles after E0.
module codec_dac_bus_parser #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  input  logic                  AUD_DACDAT,
  output logic [DATA_WIDTH-1:0] LCHAN_DATA,
  output logic [DATA_WIDTH-1:0] RCHAN_DATA,
  output logic                  DATA_VALID,
  output logic                  FRAME_ERR
);

  localparam int SW = $clog2(DATA_WIDTH + 2);
  localparam logic [SW-1:0] SLOT_FULL = SW'(DATA_WIDTH);
  localparam logic [SW-1:0] SLOT_MAX  = SW'(DATA_WIDTH + 1);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  // synchronizers: [0] first flop, [1] second flop
  logic [1:0] bclk_sync, lrck_sync, dat_sync;
  logic       bclk_d;
  logic       rise;

  // registered rise event with the LRCK/DAT samples taken alongside it
  logic       ev_vld, ev_lrck, ev_dat;

  // parser state
  state_t                state;
  logic                  prev_lrck;
  logic [SW-1:0]         slot;
  logic [DATA_WIDTH-1:0] shreg, l_hold, r_hold;
  logic                  l_ok;
  logic                  pair_go, err_go;
  logic                  word_full;

  assign rise      = bclk_sync[1] & ~bclk_d;
  assign word_full = (slot >= SLOT_FULL);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_d    <= 1'b0;
      ev_vld    <= 1'b0;
      ev_lrck   <= 1'b0;
      ev_dat    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], AUD_BCLK};
      lrck_sync <= {lrck_sync[0], AUD_DACLRCK};
      dat_sync  <= {dat_sync[0], AUD_DACDAT};
      bclk_d    <= bclk_sync[1];
      ev_vld    <= rise;
      if (rise) begin
        ev_lrck <= lrck_sync[1];
        ev_dat  <= dat_sync[1];
      end
    end
  end

  // Parser. Only cycles carrying a rise event touch the word state. The
  // right-channel complete flag never needs to persist: a complete right
  // word either pairs with a waiting left word at once (pair_go) or has
  // no partner, so it is carried only as the one-cycle pair_go.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= SYNC;
      prev_lrck  <= 1'b0;
      slot       <= '0;
      shreg      <= '0;
      l_hold     <= '0;
      r_hold     <= '0;
      l_ok       <= 1'b0;
      pair_go    <= 1'b0;
      err_go     <= 1'b0;
      LCHAN_DATA <= '0;
      RCHAN_DATA <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      pair_go    <= 1'b0;
      err_go     <= 1'b0;
      DATA_VALID <= pair_go;
      FRAME_ERR  <= err_go;
      if (pair_go) begin
        LCHAN_DATA <= l_hold;
        RCHAN_DATA <= r_hold;
      end

      if (ev_vld) begin
        prev_lrck <= ev_lrck;
        if (ev_lrck != prev_lrck) begin
          // channel boundary: this bit is the I2S delay slot, discarded
          slot <= '0;
          case (state)
            SYNC: if (!ev_lrck) state <= LEFT;
            LEFT: begin
              state <= RIGHT;
              if (word_full) begin
                l_hold <= shreg;
                l_ok   <= 1'b1;
              end else begin
                l_ok   <= 1'b0;
                err_go <= 1'b1;
              end
            end
            RIGHT: begin
              state <= LEFT;
              if (word_full) begin
                r_hold <= shreg;
                if (l_ok) begin
                  pair_go <= 1'b1;
                  l_ok    <= 1'b0;
                end
              end else begin
                err_go <= 1'b1;
              end
            end
            default: state <= SYNC;
          endcase
        end else begin
          // slot+1 is this bit's slot; slots 1..DATA_WIDTH carry the word
          if (slot < SLOT_FULL) shreg <= {shreg[DATA_WIDTH-2:0], ev_dat};
          if (slot != SLOT_MAX) slot <= slot + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_dac_bus_parser.sv
// Testbench for codec_dac_bus_parser: drives an I2S stream one channel
// segment at a time, predicts DATA_VALID / FRAME_ERR events with a
// segment-level model, and checks them through a scoreboard queue.
module tb_codec_dac_bus_parser;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          AUD_BCLK = 1'b0;
  logic          AUD_DACLRCK = 1'b0;
  logic          AUD_DACDAT = 1'b0;
  logic [DW-1:0] LCHAN_DATA, RCHAN_DATA;
  logic          DATA_VALID, FRAME_ERR;

  codec_dac_bus_parser #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .AUD_BCLK(AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
    .LCHAN_DATA(LCHAN_DATA), .RCHAN_DATA(RCHAN_DATA),
    .DATA_VALID(DATA_VALID), .FRAME_ERR(FRAME_ERR)
  );

  always #10 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            e0;
  } exp_t;
  exp_t exp_q[$];

  // segment-level reference model
  bit            m_synced = 0;
  bit            m_pend = 0;
  bit            m_pend_lr = 0;
  int            m_pend_n = 0;
  logic [DW-1:0] m_pend_w = '0;
  bit            m_l_ok = 0;
  logic [DW-1:0] m_l_w = '0;
  logic [DW-1:0] m_last_l = '0;
  logic [DW-1:0] m_last_r = '0;

  function automatic void push_exp(bit is_err, logic [DW-1:0] l, logic [DW-1:0] r, int e0);
    exp_t e;
    e.is_err = is_err; e.l = l; e.r = r; e.e0 = e0;
    exp_q.push_back(e);
  endfunction

  // A new segment with level lr has begun: close the pending one.
  function automatic void model_boundary(bit lr, int e0);
    if (m_pend && m_synced) begin
      if (!m_pend_lr) begin
        if (m_pend_n >= DW) begin m_l_ok = 1; m_l_w = m_pend_w; end
        else begin m_l_ok = 0; push_exp(1, '0, '0, e0); end
      end else begin
        if (m_pend_n >= DW) begin
          if (m_l_ok) begin
            push_exp(0, m_l_w, m_pend_w, e0);
            m_last_l = m_l_w; m_last_r = m_pend_w; m_l_ok = 0;
          end
        end else push_exp(1, '0, '0, e0);
      end
    end
    m_pend = 0;
    if (!lr) m_synced = 1;
  endfunction

  function automatic void model_reset();
    m_synced = 0; m_pend = 0; m_l_ok = 0;
    m_last_l = '0; m_last_r = '0;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_outs();
    chk("lchan_hold", LCHAN_DATA, m_last_l);
    chk("rchan_hold", RCHAN_DATA, m_last_r);
  endtask

  // One BCLK period starting with the falling edge. hook 1 releases reset
  // in the low phase, hook 2 pulses reset low for exactly one CLK edge.
  task automatic bit_cyc(bit lr, bit d, bit first, int hook);
    AUD_BCLK = 1'b0; AUD_DACLRCK = lr; AUD_DACDAT = d;
    if (hook == 1) begin
      #20 RESET_N = 1'b1;
      #20;
    end else if (hook == 2) begin
      RESET_N = 1'b0;
      #10 RESET_N = 1'b1;
      model_reset();
      chk("lchan_after_reset", LCHAN_DATA, '0);
      chk("rchan_after_reset", RCHAN_DATA, '0);
      #30;
    end else begin
      #40;
    end
    AUD_BCLK = 1'b1;
    if (first) model_boundary(lr, cyc + 1);
    #40;
  endtask

  task automatic send_seg(bit lr, logic [DW-1:0] w, int nbits, int total, int hook_slot, int hook);
    logic [DW-1:0] mw;
    mw = '0;
    for (int s = 0; s < total; s++) begin
      bit d;
      if (s >= 1 && s <= nbits) d = w[DW-s];
      else d = 1'($urandom % 2);
      if (s >= 1 && s <= DW) mw[DW-s] = d;
      bit_cyc(lr, d, s == 0, (s == hook_slot) ? hook : 0);
    end
    m_pend = 1; m_pend_lr = lr; m_pend_n = total - 1; m_pend_w = mw;
    check_outs();
  endtask

  task automatic rand_seg(bit lr);
    int n;
    if ($urandom % 6 == 0) begin
      n = $urandom_range(1, DW - 1);
      send_seg(lr, DW'($urandom), n, n + 1, -1, 0);
    end else begin
      send_seg(lr, DW'($urandom), DW, $urandom_range(DW + 1, 32), -1, 0);
    end
  endtask

  // monitor: pops one expectation per output strobe
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DATA_VALID || FRAME_ERR) begin
        checks++;
        if (DATA_VALID && FRAME_ERR) begin
          failures++;
          $display("FAIL both_strobes: DATA_VALID=1 FRAME_ERR=1 expected at most one");
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: DATA_VALID=%0b FRAME_ERR=%0b expected none", DATA_VALID, FRAME_ERR);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err != FRAME_ERR) begin
            failures++;
            $display("FAIL strobe_kind: FRAME_ERR=%0b expected %0b", FRAME_ERR, e.is_err);
          end else if (!e.is_err) begin
            if (LCHAN_DATA !== e.l || RCHAN_DATA !== e.r) begin
              failures++;
              $display("FAIL pair_data: got %h/%h expected %h/%h", LCHAN_DATA, RCHAN_DATA, e.l, e.r);
            end else if (cyc - e.e0 != 4) begin
              failures++;
              $display("FAIL valid_latency: got %0d cycles expected 4", cyc - e.e0);
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_lchan", LCHAN_DATA, '0);
    chk("reset_rchan", RCHAN_DATA, '0);
    chk("reset_valid", DW'(DATA_VALID), '0);
    chk("reset_ferr", DW'(FRAME_ERR), '0);
    #32;
    // reset released partway through a right word
    send_seg(1, DW'($urandom), DW, 32, 10, 1);
    send_seg(0, 16'h1234, DW, 32, -1, 0);
    send_seg(1, 16'hABCD, DW, 32, -1, 0);
    send_seg(0, 16'h8001, DW, 32, -1, 0);
    send_seg(1, 16'h7FFE, DW, 32, -1, 0);
    // short left word, then a good right word
    send_seg(0, DW'($urandom), 12, 13, -1, 0);
    send_seg(1, 16'h5555, DW, 32, -1, 0);
    // minimal 17-BCLK channels
    for (int i = 0; i < 3; i++) begin
      send_seg(0, DW'($urandom), DW, 17, -1, 0);
      send_seg(1, DW'($urandom), DW, 17, -1, 0);
    end
    send_seg(0, 16'hAAAA, DW, 32, -1, 0);
    send_seg(1, 16'h5555, DW, 32, -1, 0);
    // one-cycle reset in the middle of a left word
    send_seg(0, DW'($urandom), DW, 32, 8, 2);
    send_seg(1, DW'($urandom), DW, 32, -1, 0);
    send_seg(0, DW'($urandom), DW, 32, -1, 0);
    send_seg(1, DW'($urandom), DW, 32, -1, 0);
    for (int i = 0; i < 20; i++) begin
      rand_seg(0);
      rand_seg(1);
    end
    send_seg(0, DW'($urandom), DW, 20, -1, 0);
    repeat (20) @(posedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_strobes: %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/codec_dac_bus_parser.md
CODEC_DAC_BUS_PARSER -- requirements
Module: codec_dac_bus_parser

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the audio word length in bits per channel (legal 8..32).
REQ-002 Port CLK, input, 1, SHALL be the single system clock (50 MHz); every flop clocks on its rising edge.
REQ-003 Port RESET_N, input, 1, SHALL be the reset: synchronous, active-low, sampled on the CLK rising edge.
REQ-004 Port AUD_BCLK, input, 1, SHALL carry the codec bit clock; asynchronous to CLK, period >= 4 CLK periods.
REQ-005 Port AUD_DACLRCK, input, 1, SHALL carry the frame clock: low = left channel, high = right channel.
REQ-006 Port AUD_DACDAT, input, 1, SHALL carry the I2S serial data, MSB first.
REQ-007 Port LCHAN_DATA, output, DATA_WIDTH, SHALL hold the last complete left word, two's complement.
REQ-008 Port RCHAN_DATA, output, DATA_WIDTH, SHALL hold the last complete right word, two's complement.
REQ-009 Port DATA_VALID, output, 1, SHALL pulse high for one CLK cycle when both channel outputs update.
REQ-010 Port FRAME_ERR, output, 1, SHALL pulse high for one CLK cycle when a channel word closes short.

Function
REQ-011 AUD_BCLK, AUD_DACLRCK and AUD_DACDAT SHALL each pass through a 2-flop synchronizer; a BCLK rise event SHALL be derived from a third registered copy of the synchronized BCLK (sync high, delayed copy low).
REQ-012 On each BCLK rise event, synchronized LRCK and DACDAT SHALL be sampled together; no other CLK cycle changes parser state.
REQ-013 A rise event whose LRCK differs from the LRCK of the previous rise event SHALL be the channel boundary: the boundary bit is the I2S one-bit delay slot, is discarded, and resets the slot counter to 0.
REQ-014 Rise events at slots 1..DATA_WIDTH SHALL shift DACDAT into the shift register MSB first; slots > DATA_WIDTH SHALL be ignored; the slot counter SHALL saturate at DATA_WIDTH+1.
REQ-015 State machine SHALL have states SYNC, LEFT, RIGHT; reset enters SYNC.
REQ-016 SYNC: first boundary with LRCK low -> LEFT; boundary with LRCK high or no boundary -> stay SYNC; no word is captured and no error is flagged in SYNC.
REQ-017 LEFT: boundary (LRCK high) closes the left word -> RIGHT; RIGHT: boundary (LRCK low) closes the right word -> LEFT.
REQ-018 On word close, if slot counter >= DATA_WIDTH, the word SHALL be stored (left into a hold register, right into a hold register) and its complete flag set; otherwise FRAME_ERR SHALL pulse, the word is discarded, and its complete flag cleared.
REQ-019 When the right word closes complete and the left complete flag is set, LCHAN_DATA and RCHAN_DATA SHALL load from the hold registers and DATA_VALID SHALL pulse in the same cycle; both flags SHALL then clear.
REQ-020 If either word of a pair is short, outputs SHALL hold prior values and DATA_VALID SHALL not pulse for that pair.
REQ-021 Latency: DATA_VALID SHALL rise exactly 4 CLK cycles after the first CLK edge that samples the closing AUD_BCLK high.
REQ-022 DATA_VALID and FRAME_ERR SHALL never be high in the same cycle (a short right word pulses FRAME_ERR only).

Reset
REQ-023 While RESET_N is low at a CLK edge: LCHAN_DATA, RCHAN_DATA, shift register, hold registers = 0; DATA_VALID, FRAME_ERR = 0; flags cleared; slot counter = 0; state = SYNC; synchronizers = 0.
REQ-024 Reset asserted mid-word SHALL discard the partial word; after release no output changes until a full left+right pair following a LRCK-low boundary completes.

Verification
REQ-025 DATA_WIDTH=16, BCLK=CLK/4, 32 BCLK per channel, send left 0x8001, right 0x7FFE -> one DATA_VALID pulse, LCHAN_DATA=0x8001, RCHAN_DATA=0x7FFE, FRAME_ERR never high.
REQ-026 Release reset mid-right-word, then full pair left 0x1234, right 0xABCD -> no DATA_VALID for the partial frame, then one pulse with 0x1234/0xABCD, no FRAME_ERR.
REQ-027 Left word only 12 bits before LRCK rises, right 0x5555 -> one FRAME_ERR pulse at left close, no DATA_VALID, outputs retain previous pair.
REQ-028 Exactly 17 BCLK per channel (delay slot + 16 bits), 3 consecutive pairs -> 3 DATA_VALID pulses, values match, spaced 34 BCLK periods.
REQ-029 Assert RESET_N low for 1 CLK cycle mid-left-word after a valid pair 0xAAAA/0x5555 -> outputs read 0x0000/0x0000 next cycle, first following complete pair reported correctly.
REQ-030 Measure CLK cycles from first CLK edge sampling closing BCLK high to DATA_VALID -> exactly 4.
